// File: rtl/pipelined_inst_decoder_pkg.sv
// decoder_pkg: shared definitions for the GPR/multiply-add instruction decoder.
//   - opcode values (instruction bits [31:24])
//   - bit positions of the register fields inside the instruction word
//   - ALU mode encoding driven on alu_mode
//   - decoder FSM states (DEC: decoding instructions, LDATA: next word is LOAD data)
package decoder_pkg;

    localparam logic [7:0] OP_NOOP  = 8'h30;
    localparam logic [7:0] OP_LOAD  = 8'h31;
    localparam logic [7:0] OP_STORE = 8'h32;
    localparam logic [7:0] OP_MULT  = 8'h33;
    localparam logic [7:0] OP_ADD   = 8'h34;
    localparam logic [7:0] OP_MULTX = 8'h35;

    // Each register field occupies a nibble; only its low ADDR_W bits are used.
    localparam int OP_LSB = 24;
    localparam int RT_LSB = 20;
    localparam int RA_LSB = 16;
    localparam int RB_LSB = 12;
    localparam int RC_LSB = 8;

    typedef enum logic [1:0] {
        ALU_IDLE  = 2'd0,
        ALU_MULT  = 2'd1,
        ALU_ADD   = 2'd2,
        ALU_MULTX = 2'd3
    } alu_mode_t;

    typedef enum logic {
        DEC   = 1'b0,
        LDATA = 1'b1
    } dec_state_t;

endpackage

// File: rtl/pipelined_inst_decoder_y_scoreboard.sv
// y_scoreboard: tracks ALU results travelling down the Y_LAT-cycle Y pipeline.
// A {valid, addr} entry is pushed every cycle; the tail entry is the Y write
// happening this cycle. Every valid entry, tail included, is a pending write.
// Ports:
//   clock, reset_n              clock and asynchronous active-low reset
//   push_valid, push_addr       entry entering the pipeline at the next edge
//   cmp_addr_a/b/c              source addresses to check for a pending write
//   match_a/b/c                 some valid entry targets that address
//   tail_valid, tail_addr       Y write port (write enable and address)
module y_scoreboard
    import decoder_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int Y_LAT  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_valid,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [ADDR_W-1:0] cmp_addr_a,
    input  logic [ADDR_W-1:0] cmp_addr_b,
    input  logic [ADDR_W-1:0] cmp_addr_c,
    output logic              match_a,
    output logic              match_b,
    output logic              match_c,
    output logic              tail_valid,
    output logic [ADDR_W-1:0] tail_addr
);

    logic [Y_LAT-1:0]  valid_reg;
    logic [ADDR_W-1:0] addr_reg [Y_LAT];
    logic [Y_LAT-1:0]  hit_a;
    logic [Y_LAT-1:0]  hit_b;
    logic [Y_LAT-1:0]  hit_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_reg <= '0;
            for (int i = 0; i < Y_LAT; i++) begin
                addr_reg[i] <= '0;
            end
        end else begin
            valid_reg   <= {valid_reg[Y_LAT-2:0], push_valid};
            addr_reg[0] <= push_addr;
            for (int i = 1; i < Y_LAT; i++) begin
                addr_reg[i] <= addr_reg[i-1];
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < Y_LAT; gi++) begin : g_hit
            assign hit_a[gi] = valid_reg[gi] && (addr_reg[gi] == cmp_addr_a);
            assign hit_b[gi] = valid_reg[gi] && (addr_reg[gi] == cmp_addr_b);
            assign hit_c[gi] = valid_reg[gi] && (addr_reg[gi] == cmp_addr_c);
        end
    endgenerate

    assign match_a    = |hit_a;
    assign match_b    = |hit_b;
    assign match_c    = |hit_c;
    assign tail_valid = valid_reg[Y_LAT-1];
    assign tail_addr  = addr_reg[Y_LAT-1];

endmodule

// File: rtl/pipelined_inst_decoder.sv
// pipelined_inst_decoder: single-stage instruction decoder for the GPR /
// multiply-add datapath with register-hazard stalls.
// Ports:
//   clock, reset_n                 clock, asynchronous active-low reset
//   inst_bus/inst_valid/inst_ready instruction (or LOAD data) stream
//   rd_adr_a/b/c                   register-file read addresses from the decode stage
//   alu_issue, alu_mode            ALU operation issued last cycle and its mode
//   wrt_adr_x/enb_x/data_x         X (load) write port
//   wrt_adr_y/enb_y                Y (ALU result) write port, Y_LAT after issue
//   mem_write_valid                STORE operand is on the memory write bus
//   illegal_op                     one-cycle pulse when an unknown opcode retires
module pipelined_inst_decoder
    import decoder_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int Y_LAT  = 2
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [31:0]       inst_bus,
    input  logic              inst_valid,
    output logic              inst_ready,
    output logic [ADDR_W-1:0] rd_adr_a,
    output logic [ADDR_W-1:0] rd_adr_b,
    output logic [ADDR_W-1:0] rd_adr_c,
    output logic              alu_issue,
    output logic [1:0]        alu_mode,
    output logic [ADDR_W-1:0] wrt_adr_x,
    output logic              wrt_enb_x,
    output logic [31:0]       wrt_data_x,
    output logic [ADDR_W-1:0] wrt_adr_y,
    output logic              wrt_enb_y,
    output logic              mem_write_valid,
    output logic              illegal_op
);

    dec_state_t        state_reg, state_next;
    logic              ready_next;

    // Decode stage keeps only the fields the decoder actually uses.
    logic              dec_valid_reg;
    logic [7:0]        dec_op_reg;
    logic [ADDR_W-1:0] dec_rt_reg, dec_ra_reg, dec_rb_reg, dec_rc_reg;

    logic [ADDR_W-1:0] ld_adr_reg;
    logic              x_enb_reg;
    logic [ADDR_W-1:0] x_adr_reg;
    logic [31:0]       x_data_reg;
    logic              alu_issue_reg;
    alu_mode_t         alu_mode_reg;
    logic              mem_write_valid_reg;
    logic              illegal_reg;

    logic is_load, is_store, is_mult, is_add, is_multx, is_alu, is_illegal;
    alu_mode_t mode_dec;

    logic [ADDR_W-1:0] cmp_addr [3];
    logic [2:0]        use_src;
    logic [2:0]        sb_match;
    logic [2:0]        x_match;
    logic [2:0]        src_block;
    logic              hazard, issue;
    logic              take, dec_take, data_take;
    logic              sb_tail_valid;
    logic [ADDR_W-1:0] sb_tail_addr;

    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_mult    = 1'b0;
        is_add     = 1'b0;
        is_multx   = 1'b0;
        is_illegal = 1'b0;
        mode_dec   = ALU_IDLE;
        case (dec_op_reg)
            OP_NOOP:  ;
            OP_LOAD:  is_load = 1'b1;
            OP_STORE: is_store = 1'b1;
            OP_MULT:  begin is_mult  = 1'b1; mode_dec = ALU_MULT;  end
            OP_ADD:   begin is_add   = 1'b1; mode_dec = ALU_ADD;   end
            OP_MULTX: begin is_multx = 1'b1; mode_dec = ALU_MULTX; end
            default:  is_illegal = 1'b1;
        endcase
    end

    assign is_alu = is_mult || is_add || is_multx;

    // Slot 0 carries RT for LOAD (write-after-write) and STORE, RA otherwise.
    always_comb begin
        cmp_addr[0] = (is_load || is_store) ? dec_rt_reg : dec_ra_reg;
        cmp_addr[1] = dec_rb_reg;
        cmp_addr[2] = dec_rc_reg;
        use_src     = {is_add || is_multx, is_mult || is_multx, is_alu || is_load || is_store};
    end

    y_scoreboard #(
        .ADDR_W (ADDR_W),
        .Y_LAT  (Y_LAT)
    ) u_y_scoreboard (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_valid (issue && is_alu),
        .push_addr  (dec_rt_reg),
        .cmp_addr_a (cmp_addr[0]),
        .cmp_addr_b (cmp_addr[1]),
        .cmp_addr_c (cmp_addr[2]),
        .match_a    (sb_match[0]),
        .match_b    (sb_match[1]),
        .match_c    (sb_match[2]),
        .tail_valid (sb_tail_valid),
        .tail_addr  (sb_tail_addr)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_src
            assign x_match[gi]   = x_enb_reg && (x_adr_reg == cmp_addr[gi]);
            assign src_block[gi] = use_src[gi] && (sb_match[gi] || x_match[gi]);
        end
    endgenerate

    assign hazard = |src_block;
    assign issue  = dec_valid_reg && !hazard;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= DEC;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready_next = 1'b0;
        case (state_reg)
            DEC: begin
                // A LOAD issuing this cycle leaves the decode stage empty and
                // takes no word, so the following word is routed as data.
                ready_next = !dec_valid_reg || (issue && !is_load);
                if (issue && is_load) begin
                    state_next = LDATA;
                end
            end
            LDATA: begin
                ready_next = 1'b1;
                if (inst_valid) begin
                    state_next = DEC;
                end
            end
            default: state_next = DEC;
        endcase
    end

    assign inst_ready = reset_n && ready_next;
    assign take       = inst_valid && inst_ready;
    assign dec_take   = take && (state_reg == DEC);
    assign data_take  = take && (state_reg == LDATA);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dec_valid_reg       <= 1'b0;
            dec_op_reg          <= '0;
            dec_rt_reg          <= '0;
            dec_ra_reg          <= '0;
            dec_rb_reg          <= '0;
            dec_rc_reg          <= '0;
            ld_adr_reg          <= '0;
            x_enb_reg           <= 1'b0;
            x_adr_reg           <= '0;
            x_data_reg          <= '0;
            alu_issue_reg       <= 1'b0;
            alu_mode_reg        <= ALU_IDLE;
            mem_write_valid_reg <= 1'b0;
            illegal_reg         <= 1'b0;
        end else begin
            if (dec_take) begin
                dec_valid_reg <= 1'b1;
                dec_op_reg    <= inst_bus[OP_LSB +: 8];
                dec_rt_reg    <= inst_bus[RT_LSB +: ADDR_W];
                dec_ra_reg    <= inst_bus[RA_LSB +: ADDR_W];
                dec_rb_reg    <= inst_bus[RB_LSB +: ADDR_W];
                dec_rc_reg    <= inst_bus[RC_LSB +: ADDR_W];
            end else if (issue) begin
                dec_valid_reg <= 1'b0;
            end
            if (issue && is_load) begin
                ld_adr_reg <= dec_rt_reg;
            end
            x_enb_reg <= data_take;
            if (data_take) begin
                x_adr_reg  <= ld_adr_reg;
                x_data_reg <= inst_bus;
            end
            alu_issue_reg       <= issue && is_alu;
            alu_mode_reg        <= issue ? mode_dec : ALU_IDLE;
            mem_write_valid_reg <= issue && is_store;
            illegal_reg         <= issue && is_illegal;
        end
    end

    assign rd_adr_a        = is_store ? dec_rt_reg : dec_ra_reg;
    assign rd_adr_b        = dec_rb_reg;
    assign rd_adr_c        = dec_rc_reg;
    assign alu_issue       = alu_issue_reg;
    assign alu_mode        = alu_mode_reg;
    assign wrt_enb_x       = x_enb_reg;
    assign wrt_adr_x       = x_adr_reg;
    assign wrt_data_x      = x_data_reg;
    assign wrt_enb_y       = sb_tail_valid;
    assign wrt_adr_y       = sb_tail_addr;
    assign mem_write_valid = mem_write_valid_reg;
    assign illegal_op      = illegal_reg;

endmodule
